kernel_jacobi_2d_udiv_seq: RTL and testbench
============================================

# kernel_jacobi_2d_udiv_seq

Sequential unsigned divider for the jacobi-2d kernel datapath. It is the inverse of the pipelined index multiplier: it splits a flat array offset (row × N + col) back into quotient (row) and remainder (col), and it also serves general unsigned divide operations. It uses a radix-2 restoring algorithm, one quotient bit per enabled clock, with a start/done handshake. It follows the same `ce` clock-enable convention as the other arithmetic cores in the kernel.

## Interface
Parameters:
- `ID`, 32'd1, instance identifier; no functional effect.
- `din0_WIDTH`, 32'd20, dividend width; also sets quotient width and iteration count.
- `din1_WIDTH`, 32'd11, divisor width; also sets remainder width.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset. It takes priority over `ce`.
- `ce`  in  1  clock enable. When low, all state, including the outputs, holds.
- `start`  in  1  request. Sampled only when `ce`=1.
- `din0`  in  din0_WIDTH  dividend. Sampled with `start`.
- `din1`  in  din1_WIDTH  divisor. Sampled with `start`.
- `busy`  out  1  high while in CALC.
- `done`  out  1  one-enabled-cycle pulse: result valid.
- `quo`  out  din0_WIDTH  quotient.
- `rem`  out  din1_WIDTH  remainder.

## Operation
States: IDLE, CALC, DONE.
- **IDLE:** on `start`=1 with `ce`=1:
  - latch the dividend into the shift register and the divisor into a register;
  - clear the partial remainder (din1_WIDTH+1 bits) and the iteration counter;
  - go to CALC.
- **CALC:** each enabled cycle performs one iteration:
  - shift {partial remainder, dividend} left by 1;
  - trial = partial remainder − divisor;
  - if trial ≥ 0, the partial remainder takes the trial value and the quotient LSB is 1; otherwise the LSB is 0.
  - After din0_WIDTH iterations, register `quo` and `rem` and go to DONE.
- **DONE:** `done`=1 for one enabled cycle.
  - Next state is CALC if `start`=1 (new operands latched), otherwise IDLE.
- **`start` in CALC:** ignored. It is not queued.
- **Divide by zero (`din1`=0):** still takes the full latency. Result is `quo` = all ones and `rem` = dividend[din1_WIDTH-1:0]. This is the natural restoring result and needs no special-case logic.
- **Output hold:** `quo` and `rem` hold the last result until the next completion. They are not cleared on a new `start`.
- **Arithmetic:** all unsigned. The invariant is quo×din1 + rem = din0 and rem < din1 for din1 ≠ 0. The remainder always fits din1_WIDTH bits.

## Timing
- **Reset:** state = IDLE; `busy`=0, `done`=0, `quo`=0, `rem`=0; counter cleared.
- **Latency,** counted in enabled edges with `start` sampled at edge 0:
  - `busy`=1 after edges 0 through 19;
  - `quo`/`rem` are updated at edge 20, and `done`=1 and `busy`=0 after edge 20;
  - `done` falls after edge 21 (if `ce`=1 there).
  - In general this is din0_WIDTH enabled edges from start to result.
- **Throughput:** back-to-back operation is possible. A `start` asserted during DONE begins a new operation at that edge, so the interval is din0_WIDTH+1 cycles.
- **`ce`=0 stall:** freezes the state, counter and outputs. A held `done` stays high across the stall. Latency in raw clocks grows by the number of stalled cycles.
- **`start`=1 with `ce`=0:** ignored.
- **Reset mid-CALC:** the operation is aborted. Outputs return to their reset values at the next edge, and no `done` is produced.
- **Reset and `start` in the same cycle:** reset wins and the operation is not started.

## Test plan
- **Basic divide:** `din0`=1000000, `din1`=7, start pulse → after 20 enabled edges `done`=1 for 1 cycle, `quo`=142857, `rem`=1. `busy` is high for exactly 20 cycles.
- **Index split and extremes:**
  - `din0`=12345, `din1`=2047 → `quo`=6, `rem`=63.
  - `din0`=1048575, `din1`=1 → `quo`=1048575, `rem`=0.
  - `din0`=5, `din1`=9 → `quo`=0, `rem`=5.
- **Divide by zero:** `din0`=1000, `din1`=0 → `quo`=1048575, `rem`=1000, with `done` at the normal latency.
- **Handshake:**
  - `start` re-asserted at cycles 5 and 10 of CALC with other operands → ignored; the first result is unchanged.
  - `start` during DONE with 100/3 → the next `done` arrives 21 cycles after the first, with `quo`=33, `rem`=1.
- **Clock enable:** `ce` toggled 1/0 every cycle during 1000000/7 → the result is unchanged, `done` arrives after 40 raw cycles, and `done` is held while `ce`=0.
- **Reset mid-operation:** `reset` at cycle 10 of CALC → the next cycle shows `busy`=0, `done`=0, `quo`=0, `rem`=0 and state IDLE. A subsequent 100/3 completes correctly.
- **Self-check:** 10k random (`din0`, `din1`≠0) pairs are checked against a reference model using quo×din1 + rem = din0 and rem < din1.

Source files
------------

// File: rtl/kernel_jacobi_2d_udiv_seq.sv
// Radix-2 restoring unsigned divider with start/done handshake and clock enable.
// One quotient bit per enabled clock; din0_WIDTH enabled edges from start to result.
module kernel_jacobi_2d_udiv_seq #(
    parameter int unsigned ID         = 32'd1,
    parameter int unsigned din0_WIDTH = 32'd20,
    parameter int unsigned din1_WIDTH = 32'd11
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  start,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  busy,
    output logic                  done,
    output logic [din0_WIDTH-1:0] quo,
    output logic [din1_WIDTH-1:0] rem
);
    localparam int unsigned CW = $clog2(din0_WIDTH + 1);
    localparam int unsigned PW = din1_WIDTH + 1;
    localparam logic [CW-1:0] LAST = CW'(din0_WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t                r_state, w_state_nx;
    logic [CW-1:0]         r_cnt;
    logic [din0_WIDTH-1:0] r_dvd;
    logic [din1_WIDTH-1:0] r_dsr;
    logic [PW-1:0]         r_prem;
    logic [PW:0]           w_shift;
    logic                  w_ge;
    logic [PW-1:0]         w_prem_nx;
    logic [din0_WIDTH-1:0] w_quo_nx;
    logic                  w_load;
    logic                  w_last;

    // Dividend register doubles as the quotient accumulator: bits shift out the
    // top into the partial remainder while quotient bits enter at the bottom.
    assign w_shift   = {r_prem, r_dvd[din0_WIDTH-1]};
    assign w_ge      = w_shift >= (PW + 1)'(r_dsr);
    assign w_prem_nx = w_ge ? PW'(w_shift - (PW + 1)'(r_dsr)) : w_shift[PW-1:0];
    assign w_quo_nx  = {r_dvd[din0_WIDTH-2:0], w_ge};
    assign w_last    = (r_cnt == LAST);

    assign busy = (r_state == S_CALC);
    assign done = (r_state == S_DONE);

    always_ff @(posedge clk) begin
        if (reset)   r_state <= S_IDLE;
        else if (ce) r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        w_load     = 1'b0;
        case (r_state)
            S_IDLE: if (start) begin
                w_load     = 1'b1;
                w_state_nx = S_CALC;
            end
            S_CALC: if (w_last) w_state_nx = S_DONE;
            S_DONE: begin
                if (start) begin
                    w_load     = 1'b1;
                    w_state_nx = S_CALC;
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_dvd  <= '0;
            r_dsr  <= '0;
            r_prem <= '0;
            quo    <= '0;
            rem    <= '0;
        end else if (ce) begin
            if (w_load) begin
                r_dvd  <= din0;
                r_dsr  <= din1;
                r_prem <= '0;
                r_cnt  <= '0;
            end else if (r_state == S_CALC) begin
                r_dvd  <= w_quo_nx;
                r_prem <= w_prem_nx;
                r_cnt  <= r_cnt + 1'b1;
                // Final iteration's result goes straight to the outputs.
                if (w_last) begin
                    quo <= w_quo_nx;
                    rem <= w_prem_nx[din1_WIDTH-1:0];
                end
            end
        end
    end
endmodule

// File: tb/tb_kernel_jacobi_2d_udiv_seq.sv
// Bench for kernel_jacobi_2d_udiv_seq: directed literal checks plus a long random
// run, with every cycle compared against a latency/arithmetic reference model.
module tb_kernel_jacobi_2d_udiv_seq;
    localparam int W0 = 20;
    localparam int W1 = 11;
    localparam int LAT = W0;

    logic          clk = 1'b0;
    logic          reset, ce, start;
    logic [W0-1:0] din0;
    logic [W1-1:0] din1;
    logic          busy, done;
    logic [W0-1:0] quo;
    logic [W1-1:0] rem;

    int n_vec = 0;
    int n_err = 0;
    bit cmp_on = 1'b0;

    kernel_jacobi_2d_udiv_seq #(.ID(32'd1), .din0_WIDTH(W0), .din1_WIDTH(W1)) dut (
        .clk(clk), .reset(reset), .ce(ce), .start(start), .din0(din0), .din1(din1),
        .busy(busy), .done(done), .quo(quo), .rem(rem)
    );

    always #5 clk = ~clk;

    // Reference: a request is accepted whenever not busy; the answer is plain
    // integer division, published LAT enabled edges later.
    logic          m_busy = 1'b0, m_done = 1'b0;
    logic [W0-1:0] m_quo = '0, p_quo = '0;
    logic [W1-1:0] m_rem = '0, p_rem = '0;
    int            m_left = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_quo <= '0; m_rem <= '0; m_left <= 0;
        end else if (ce) begin
            if (m_busy) begin
                if (m_left == 1) begin
                    m_busy <= 1'b0; m_done <= 1'b1;
                    m_quo  <= p_quo; m_rem <= p_rem; m_left <= 0;
                end else begin
                    m_left <= m_left - 1;
                end
            end else begin
                m_done <= 1'b0;
                if (start) begin
                    p_quo  <= (din1 == 0) ? {W0{1'b1}} : din0 / W0'(din1);
                    p_rem  <= (din1 == 0) ? din0[W1-1:0] : W1'(din0 % W0'(din1));
                    m_left <= LAT;
                    m_busy <= 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        if (cmp_on) begin
            n_vec++;
            if ({busy, done, quo, rem} !== {m_busy, m_done, m_quo, m_rem}) begin
                n_err++;
                $display("FAIL cycle @%0t: got busy=%0b done=%0b quo=%0d rem=%0d want busy=%0b done=%0b quo=%0d rem=%0d",
                         $time, busy, done, quo, rem, m_busy, m_done, m_quo, m_rem);
            end
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // Issues start at the current negedge, returns at the negedge where done=1.
    task automatic run_op(input int a, input int b, input bit toggle, input bit poke,
                          output int bc, output int raw);
        start = 1'b1; din0 = W0'(a); din1 = W1'(b); ce = 1'b1;
        tick();
        start = 1'b0; bc = 0; raw = 0;
        while (!done && raw < 200) begin
            if (busy) bc++;
            ce = toggle ? ~ce : 1'b1;
            if (poke && (raw == 5 || raw == 10)) begin
                start = 1'b1; din0 = W0'(100); din1 = W1'(3);
            end else begin
                start = 1'b0;
            end
            tick();
            raw++;
        end
        start = 1'b0;
        if (raw >= 200) chk("done_timeout", raw, 0);
    endtask

    int bc, raw;
    int tv[4][4] = '{'{12345, 2047, 6, 63}, '{1048575, 1, 1048575, 0},
                     '{5, 9, 0, 5}, '{1000, 0, 1048575, 1000}};

    initial begin
        reset = 1'b1; ce = 1'b0; start = 1'b0; din0 = '0; din1 = '0;
        tick();
        cmp_on = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_quo", int'(quo), 0);
        chk("reset_rem", int'(rem), 0);
        reset = 1'b0;
        tick();

        run_op(1000000, 7, 1'b0, 1'b0, bc, raw);
        chk("basic_busy_cycles", bc, 20);
        chk("basic_latency", raw, 20);
        chk("basic_quo", int'(quo), 142857);
        chk("basic_rem", int'(rem), 1);
        tick();
        chk("basic_done_pulse", int'(done), 0);

        for (int i = 0; i < 4; i++) begin
            run_op(tv[i][0], tv[i][1], 1'b0, 1'b0, bc, raw);
            chk("vec_latency", raw, 20);
            chk("vec_quo", int'(quo), tv[i][2]);
            chk("vec_rem", int'(rem), tv[i][3]);
            tick();
        end

        run_op(1000000, 7, 1'b0, 1'b1, bc, raw);
        chk("ignored_start_quo", int'(quo), 142857);
        chk("ignored_start_rem", int'(rem), 1);
        run_op(100, 3, 1'b0, 1'b0, bc, raw);
        chk("b2b_interval", raw + 1, 21);
        chk("b2b_quo", int'(quo), 33);
        chk("b2b_rem", int'(rem), 1);
        tick();

        run_op(1000000, 7, 1'b1, 1'b0, bc, raw);
        chk("ce_latency_raw", raw, 40);
        chk("ce_quo", int'(quo), 142857);
        chk("ce_rem", int'(rem), 1);
        ce = 1'b0;
        tick();
        chk("ce_done_held", int'(done), 1);
        ce = 1'b1;
        tick();
        chk("ce_done_fall", int'(done), 0);

        start = 1'b1; din0 = W0'(1000000); din1 = W1'(7);
        tick();
        start = 1'b0;
        repeat (10) tick();
        reset = 1'b1;
        tick();
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_quo", int'(quo), 0);
        chk("abort_rem", int'(rem), 0);
        reset = 1'b0;
        run_op(100, 3, 1'b0, 1'b0, bc, raw);
        chk("post_abort_quo", int'(quo), 33);
        chk("post_abort_rem", int'(rem), 1);

        for (int c = 0; c < 30000; c++) begin
            reset = ($urandom_range(999) == 0);
            ce    = ($urandom_range(3) != 0);
            start = ($urandom_range(2) == 0);
            din0  = W0'($urandom);
            din1  = ($urandom_range(15) == 0) ? '0 : W1'($urandom);
            tick();
        end
        reset = 1'b0; start = 1'b0; ce = 1'b1;
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
